// File: rtl/divider_ctrl_if.sv
// Divisor configuration handshake between a requester and divider_ctrl.
interface divider_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/divider_ctrl.sv
// Programmable divide-by-D tick generator with start/stop, one-shot and boundary-safe divisor updates.
// Optional square-wave output sq_out enabled by defining DIVIDER_CTRL_DUTY50_EN.
module divider_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  divider_ctrl_if.slave    cfg,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_active
`ifdef DIVIDER_CTRL_DUTY50_EN
  ,
  output logic             sq_out
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             oneshot_q, oneshot_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic wrap;
  logic cfg_ready_int;
  logic cfg_fire;
  logic cfg_legal;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      div_q     <= WIDTH'(DEFAULT_DIV);
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      oneshot_q <= oneshot_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state, counter and configuration logic
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    div_d     = div_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    oneshot_d = oneshot_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    wrap          = (state_q != IDLE) && (count_q == (div_q - WIDTH'(1)));
    cfg_ready_int = !rst && ((state_q == IDLE) || !pend_v_q);
    cfg_fire      = cfg.cfg_valid && cfg_ready_int;
    cfg_legal     = (cfg.cfg_div >= WIDTH'(2));
    err_d         = cfg_fire && !cfg_legal;

    case (state_q)
      IDLE: begin
        count_d  = '0;
        pend_v_d = 1'b0;
        if (cfg_fire && cfg_legal) begin
          div_d = cfg.cfg_div;
        end
        if (start) begin
          state_d   = RUN;
          oneshot_d = oneshot;
        end
      end
      default: begin
        count_d = wrap ? '0 : count_q + WIDTH'(1);
        // Pending set on an earlier cycle is applied at this period boundary
        if (wrap && pend_v_q) begin
          div_d    = pend_q;
          pend_v_d = 1'b0;
        end
        if (cfg_fire && cfg_legal) begin
          pend_d   = cfg.cfg_div;
          pend_v_d = 1'b1;
        end
        if (wrap && ((state_q == STOPPING) || stop || oneshot_q)) begin
          state_d  = IDLE;
          count_d  = '0;
          div_d    = div_q;
          pend_v_d = 1'b0;
          done_d   = 1'b1;
        end else if ((state_q == RUN) && stop) begin
          state_d = STOPPING;
        end
      end
    endcase
  end

  assign tick          = !rst && wrap;
  assign busy          = !rst && (state_q != IDLE);
  assign done          = !rst && done_q;
  assign err           = !rst && err_q;
  assign count         = count_q;
  assign div_active    = div_q;
  assign cfg.cfg_ready = cfg_ready_int;

`ifdef DIVIDER_CTRL_DUTY50_EN
  // High phase is ceil(D/2) cycles; one extra bit avoids overflow at D = 2^WIDTH-1
  logic [WIDTH:0] half_period;
  assign half_period = ((WIDTH+1)'(div_q) + (WIDTH+1)'(1)) >> 1;
  assign sq_out      = !rst && (state_q != IDLE) && ((WIDTH+1)'(count_q) < half_period);
`endif

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed self-checking bench for divider_ctrl.
module tb_divider_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             oneshot;
  logic             tick;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_active;
`ifdef DIVIDER_CTRL_DUTY50_EN
  logic             sq_out;
`endif

  int checks   = 0;
  int failures = 0;

  divider_ctrl_if #(.WIDTH(WIDTH)) cfg_bus ();

  divider_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .oneshot    (oneshot),
    .cfg        (cfg_bus),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .count      (count),
    .div_active (div_active)
`ifdef DIVIDER_CTRL_DUTY50_EN
    ,
    .sq_out     (sq_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    start             = 1'b0;
    stop              = 1'b0;
    oneshot           = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_div   = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (cfg_bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=0", cfg_bus.cfg_ready); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
    rst = 1'b0;
    step();
    checks++; if (count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (div_active !== 8'd4) begin failures++; $display("FAIL reset_div got=%0d exp=4", div_active); end
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL idle_cfg_ready got=%b exp=1", cfg_bus.cfg_ready); end
  endtask

  task automatic test_free_run();
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      start = 1'b0;
      checks++; if (tick !== ((c % 4) == 0)) begin failures++; $display("FAIL free_tick c=%0d got=%b exp=%b", c, tick, (c % 4) == 0); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL free_busy c=%0d got=%b exp=1", c, busy); end
      checks++; if (count !== 8'((c - 1) % 4)) begin failures++; $display("FAIL free_count c=%0d got=%0d exp=%0d", c, count, (c - 1) % 4); end
    end
  endtask

  task automatic test_cfg_midrun();
    logic exp_t;
    logic exp_r;
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      start = 1'b0;
      exp_t = (c == 4) || (c == 8) || (c == 14) || (c == 20);
      exp_r = !((c >= 6) && (c <= 8));
      checks++; if (tick !== exp_t) begin failures++; $display("FAIL cfg_tick c=%0d got=%b exp=%b", c, tick, exp_t); end
      checks++; if (cfg_bus.cfg_ready !== exp_r) begin failures++; $display("FAIL cfg_ready c=%0d got=%b exp=%b", c, cfg_bus.cfg_ready, exp_r); end
      if (c == 8) begin
        checks++; if (div_active !== 8'd4) begin failures++; $display("FAIL cfg_div_old got=%0d exp=4", div_active); end
      end
      if (c == 9) begin
        checks++; if (div_active !== 8'd6) begin failures++; $display("FAIL cfg_div_new got=%0d exp=6", div_active); end
      end
      cfg_bus.cfg_valid = (c == 5);
      cfg_bus.cfg_div   = (c == 5) ? 8'd6 : 8'd0;
    end
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic test_stop(input int stop_cyc, input int last_tick);
    logic exp_t;
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= last_tick + 6; c++) begin
      step();
      start = 1'b0;
      exp_t = ((c % 4) == 0) && (c <= last_tick);
      checks++; if (tick !== exp_t) begin failures++; $display("FAIL stop_tick s=%0d c=%0d got=%b exp=%b", stop_cyc, c, tick, exp_t); end
      checks++; if (busy !== (c <= last_tick)) begin failures++; $display("FAIL stop_busy s=%0d c=%0d got=%b exp=%b", stop_cyc, c, busy, c <= last_tick); end
      checks++; if (done !== (c == last_tick + 1)) begin failures++; $display("FAIL stop_done s=%0d c=%0d got=%b exp=%b", stop_cyc, c, done, c == last_tick + 1); end
      stop = (c == stop_cyc);
    end
    stop = 1'b0;
  endtask

  task automatic test_oneshot();
    do_reset();
    start             = 1'b1;
    oneshot           = 1'b1;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 8'd5;
    for (int c = 1; c <= 11; c++) begin
      step();
      start             = 1'b0;
      oneshot           = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      checks++; if (tick !== (c == 5)) begin failures++; $display("FAIL os_tick c=%0d got=%b exp=%b", c, tick, c == 5); end
      checks++; if (done !== (c == 6)) begin failures++; $display("FAIL os_done c=%0d got=%b exp=%b", c, done, c == 6); end
      checks++; if (busy !== (c <= 5)) begin failures++; $display("FAIL os_busy c=%0d got=%b exp=%b", c, busy, c <= 5); end
    end
    checks++; if (div_active !== 8'd5) begin failures++; $display("FAIL os_div got=%0d exp=5", div_active); end
  endtask

  task automatic test_illegal_cfg();
    do_reset();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 8'd1;
    step();
    cfg_bus.cfg_div = 8'd0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill1_err got=%b exp=1", err); end
    checks++; if (div_active !== 8'd4) begin failures++; $display("FAIL ill1_div got=%0d exp=4", div_active); end
    step();
    cfg_bus.cfg_valid = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill0_err got=%b exp=1", err); end
    step();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_err_clear got=%b exp=0", err); end
    checks++; if (div_active !== 8'd4) begin failures++; $display("FAIL ill0_div got=%0d exp=4", div_active); end
  endtask

  task automatic test_max_div();
    int max_cnt;
    max_cnt = 0;
    do_reset();
    start             = 1'b1;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 8'd255;
    for (int c = 1; c <= 520; c++) begin
      step();
      start             = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      checks++; if (tick !== ((c % 255) == 0)) begin failures++; $display("FAIL max_tick c=%0d got=%b exp=%b", c, tick, (c % 255) == 0); end
      if (c == 255 || c == 256) begin
        checks++; if (count !== 8'((c - 1) % 255)) begin failures++; $display("FAIL max_count c=%0d got=%0d exp=%0d", c, count, (c - 1) % 255); end
      end
    end
    checks++; if (max_cnt != 254) begin failures++; $display("FAIL max_peak got=%0d exp=254", max_cnt); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL rmid_tick got=%b exp=0", tick); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    rst = 1'b0;
    step();
    checks++; if (count !== 8'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", count); end
    checks++; if (div_active !== 8'd4) begin failures++; $display("FAIL rmid_div got=%0d exp=4", div_active); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_done_busy got=%b%b exp=00", done, busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start   = 1'b1;
    oneshot = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      // restart on the done cycle; second one-shot ticks 4 cycles later
      start   = (c == 5);
      oneshot = (c == 5);
      checks++; if (tick !== (c == 4 || c == 9)) begin failures++; $display("FAIL b2b_tick c=%0d got=%b exp=%b", c, tick, c == 4 || c == 9); end
    end
    start   = 1'b0;
    oneshot = 1'b0;
  endtask

`ifdef DIVIDER_CTRL_DUTY50_EN
  task automatic test_duty50();
    do_reset();
    start             = 1'b1;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 8'd5;
    for (int c = 1; c <= 10; c++) begin
      step();
      start             = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      checks++; if (sq_out !== (((c - 1) % 5) < 3)) begin failures++; $display("FAIL duty_sq c=%0d got=%b exp=%b", c, sq_out, ((c - 1) % 5) < 3); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_cfg_midrun();
    test_stop(9, 12);
    test_stop(8, 8);
    test_oneshot();
    test_illegal_cfg();
    test_max_div();
    test_reset_midrun();
    test_back_to_back();
`ifdef DIVIDER_CTRL_DUTY50_EN
    test_duty50();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divider_ctrl.md
Name: divider_ctrl

Overview:
- Sequencing controller for the team's N-bit synchronous counters in the division devices library.
- Owns a WIDTH-bit up-counter and turns it into a programmable divide-by-D tick generator.
- Provides start/stop control, one-shot mode, and a valid/ready divisor-configuration port.
- New divisors are applied only at period boundaries, so tick spacing is never corrupted mid-period.

Parameters:
- WIDTH, 8, width of the internal counter and of the divisor.
- DEFAULT_DIV, 4, divisor loaded at reset. Legal range is 2 to 2^WIDTH-1.

Ports:
- clk  input  1  single system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled request to begin dividing.
- stop  input  1  request to end after the current period.
- oneshot  input  1  sampled together with an accepted start; 1 means emit exactly one tick.
- cfg_valid  input  1  divisor update request.
- cfg_div  input  WIDTH  requested divisor D.
- cfg_ready  output  1  controller can accept cfg_div this cycle.
- tick  output  1  one-cycle pulse, once per D cycles.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when returning to IDLE.
- err  output  1  one-cycle pulse on an illegal divisor.
- count  output  WIDTH  current counter value.
- div_active  output  WIDTH  divisor currently in use.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset (rst) is synchronous and active-high.
  - Reset values: state=IDLE, count=0, div_active=DEFAULT_DIV, pending register empty.
  - Reset values of outputs: tick=0, busy=0, done=0, err=0, cfg_ready=0 while rst is high.
  - Reset asserted mid-operation aborts immediately: no tick, no done.
- State machine (IDLE, RUN, STOPPING):
  - IDLE: count held at 0. start=1 -> RUN with count=0 next cycle; the oneshot flag is latched.
  - RUN: count increments each cycle. When count==div_active-1 it wraps to 0.
  - RUN + stop=1 -> STOPPING, unless this is a wrap cycle; then that tick is final and the next state is IDLE.
  - STOPPING: keeps counting; the wrap cycle emits a tick, then goes to IDLE.
  - Oneshot latched: the first wrap -> IDLE.
  - done pulses on the cycle after any transition into IDLE, except a transition caused by reset.
  - start in RUN/STOPPING is ignored. stop in IDLE is ignored. start+stop together in IDLE: start wins.
- tick:
  - tick = (state!=IDLE) && (count==div_active-1), decoded from registers only.
  - With start accepted at cycle 0, ticks occur at cycles D, 2D, 3D, and so on.
- Configuration handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - IDLE: cfg_ready=1; an accepted value loads div_active next cycle.
  - cfg and start in the same IDLE cycle: the first period uses the new D.
  - RUN/STOPPING: cfg_ready=1 only while pending is empty. An accepted value goes to pending.
  - Pending is copied to div_active on the next wrap cycle strictly after acceptance, so a cfg accepted on a wrap cycle applies one period later.
  - Pending is discarded on entry to IDLE.
  - cfg_div of 0 or 1: the handshake completes, err pulses next cycle, and div_active/pending are unchanged.
- Counter width: arithmetic is modulo 2^WIDTH. With D=2^WIDTH-1, count peaks at 2^WIDTH-2 and never overflows.

Optional Feature:
- Macro: DIVIDER_CTRL_DUTY50_EN.
- Defined: adds output sq_out (1 bit), high while state!=IDLE and count < ceil(div_active/2), otherwise low. For odd D the high phase is one cycle longer. Reset value is 0.
- Undefined: port sq_out and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start=1 at cycle 0 with D=4 (default), oneshot=0 -> ticks at cycles 4, 8, 12; busy=1 from cycle 1.
- Running with D=4; cfg_div=6 accepted at cycle 5 -> tick at 8 (old D), then 14, 20. cfg_ready low from cycle 6 until cycle 9.
- stop=1 at cycle 9 with D=4 -> final tick at 12, IDLE at 13, done pulse at 13. Separately, stop coincident with the tick at 8 -> no further ticks, done at 9.
- oneshot=1 with start, D=5 -> single tick at cycle 5, done at 6, no tick at 10.
- cfg_div=1 in IDLE -> err pulse next cycle, div_active stays 4. cfg_div=255 with WIDTH=8 -> ticks every 255 cycles, count max 254.
- rst asserted at cycle 3 of a D=4 run -> no tick at 4, busy=0, count=0, div_active=4 after reset. With DUTY50_EN and D=5: sq_out high for 3 cycles, low for 2.
